// File: rtl/ahb_slave_mem.sv
// AHB responder backed by a word-addressed register-file memory.
// Inserts WAIT_STATES wait cycles per OKAY transfer; illegal accesses get a two-cycle ERROR.
//
// Ports:
//   hclk       bus clock, all state updates on the rising edge
//   hreset     asynchronous active-high reset
//   hsel       slave select from the decoder (address phase)
//   haddr      byte address
//   hwrite     1 = write, 0 = read
//   htrans     IDLE/BUSY/NONSEQ/SEQ
//   hwdata     write data (data phase)
//   hready_in  bus-level hready, qualifies the address phase
//   hrdata     read data, zero outside read data cycles
//   hreadyout  this slave's transfer-done indication
//   hresp      00 OKAY, 01 ERROR
module ahb_slave_mem #(
    parameter int MEM_AW      = 6,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic [1:0]  hresp
);

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b01;
    localparam logic [3:0] WS_LOAD   =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [3:0]          wcnt;
    logic [3:0]          wcnt_nx;
    logic [MEM_AW-1:0]   idx;
    logic [MEM_AW-1:0]   idx_nx;
    logic                wr_l;
    logic                wr_nx;
    logic                accept;
    logic                legal;
    logic                unused_trans;

    logic [31:0] mem [2**MEM_AW];

    // Only NONSEQ/SEQ carry a transfer; htrans[0] (SEQ vs NONSEQ) is irrelevant here.
    assign unused_trans = htrans[0];
    assign accept = hsel && hready_in && htrans[1];
    assign legal  = (haddr[1:0] == 2'b00) && (haddr[31:MEM_AW+2] == '0);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= S_IDLE;
            wcnt  <= 4'd0;
            idx   <= '0;
            wr_l  <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            idx   <= idx_nx;
            wr_l  <= wr_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        wcnt_nx   = wcnt;
        idx_nx    = idx;
        wr_nx     = wr_l;
        hreadyout = 1'b1;
        hresp     = RESP_OKAY;
        case (state)
            // Every state that drives hreadyout high may take the next
            // address phase on the same edge (pipelining).
            S_IDLE, S_DATA, S_ERR2: begin
                if (state == S_ERR2) begin
                    hresp = RESP_ERR;
                end
                if (accept) begin
                    idx_nx = haddr[MEM_AW+1:2];
                    wr_nx  = hwrite && legal;
                    if (!legal) begin
                        state_nx = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nx = S_WAIT;
                        wcnt_nx  = WS_LOAD;
                    end else begin
                        state_nx = S_DATA;
                    end
                end else begin
                    state_nx = S_IDLE;
                    wr_nx    = 1'b0;
                end
            end
            S_WAIT: begin
                hreadyout = 1'b0;
                if (wcnt == 4'd0) begin
                    state_nx = S_DATA;
                end else begin
                    wcnt_nx = wcnt - 4'd1;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = RESP_ERR;
                state_nx  = S_ERR2;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // The write lands at the edge closing the data phase, so a read whose
    // data phase starts at that same edge already sees the new word.
    always_ff @(posedge hclk) begin
        if (!hreset && state == S_DATA && wr_l) begin
            mem[idx] <= hwdata;
        end
    end

    assign hrdata = (state == S_DATA && !wr_l) ? mem[idx] : 32'd0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Testbench for ahb_slave_mem: three instances with 0, 1 and 2 wait states,
// driven by a pipelined master and checked against a transfer-level model.
module tb_ahb_slave_mem;

    localparam int AW = 6;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] hwdata = '0;
    logic        hready_bus;
    int          act = 0;

    logic [31:0] hrdata_w [3];
    logic        hro_w [3];
    logic [1:0]  hresp_w [3];
    logic        hsel_v [3];

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [3][64];

    logic        t_sel [64];
    logic [1:0]  t_trans [64];
    logic [31:0] t_addr [64];
    logic        t_write [64];
    logic [31:0] t_data [64];

    always #5 hclk = ~hclk;

    assign hready_bus = hro_w[act];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign hsel_v[g] = hsel && (act == g);
        ahb_slave_mem #(
            .MEM_AW(AW),
            .WAIT_STATES(g)
        ) u_dut (
            .hclk(hclk),
            .hreset(hreset),
            .hsel(hsel_v[g]),
            .haddr(haddr),
            .hwrite(hwrite),
            .htrans(htrans),
            .hwdata(hwdata),
            .hready_in(hready_bus),
            .hrdata(hrdata_w[g]),
            .hreadyout(hro_w[g]),
            .hresp(hresp_w[g])
        );
    end

    function automatic bit is_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
    endfunction

    function automatic bit is_xfer(input int i);
        return t_sel[i] && t_trans[i][1];
    endfunction

    task automatic set_t(input int i, input logic s, input logic [1:0] tr,
                         input logic [31:0] a, input logic w,
                         input logic [31:0] dat);
        t_sel[i]   = s;
        t_trans[i] = tr;
        t_addr[i]  = a;
        t_write[i] = w;
        t_data[i]  = dat;
    endtask

    // Pipelined master over t_*[0..n-1] against instance k (k wait states).
    // Each data phase is checked cycle by cycle against the model.
    task automatic run(input int k, input int n, output int cyc,
                       output logic [31:0] last_rd);
        int a = 0;
        int d = -1;
        int cnt = 0;
        bit er;
        logic [1:0] ep;
        logic [31:0] ed;
        cyc = 0;
        last_rd = '0;
        act = k;
        while ((a < n || d >= 0) && cyc < 1000) begin
            if (a < n) begin
                hsel   = t_sel[a];
                haddr  = t_addr[a];
                hwrite = t_write[a];
                htrans = t_trans[a];
            end else begin
                hsel   = 1'b0;
                htrans = 2'b00;
                haddr  = $urandom;
                hwrite = 1'($urandom);
            end
            hwdata = (d >= 0) ? t_data[d] : $urandom;
            @(negedge hclk);
            if (d < 0) begin
                er = 1'b1;
                ep = 2'b00;
                ed = '0;
            end else if (is_legal(t_addr[d])) begin
                er = (cnt == k);
                ep = 2'b00;
                ed = (er && !t_write[d]) ? ref_mem[k][t_addr[d][7:2]] : '0;
            end else begin
                er = (cnt == 1);
                ep = 2'b01;
                ed = '0;
            end
            checks++;
            if (hro_w[k] !== er) begin
                errors++;
                $display("FAIL hreadyout ws=%0d cyc=%0d got=%b exp=%b",
                         k, cyc, hro_w[k], er);
            end
            checks++;
            if (hresp_w[k] !== ep) begin
                errors++;
                $display("FAIL hresp ws=%0d cyc=%0d got=%b exp=%b",
                         k, cyc, hresp_w[k], ep);
            end
            checks++;
            if (hrdata_w[k] !== ed) begin
                errors++;
                $display("FAIL hrdata ws=%0d cyc=%0d got=%h exp=%h",
                         k, cyc, hrdata_w[k], ed);
            end
            if (d >= 0 && er && !t_write[d]) begin
                last_rd = hrdata_w[k];
            end
            @(posedge hclk);
            #1;
            if (er) begin
                if (d >= 0 && is_legal(t_addr[d]) && t_write[d]) begin
                    ref_mem[k][t_addr[d][7:2]] = t_data[d];
                end
                if (a < n) begin
                    d = is_xfer(a) ? a : -1;
                    a++;
                    cnt = 0;
                end else begin
                    d = -1;
                end
            end else begin
                cnt++;
            end
            cyc++;
        end
        checks++;
        if (a < n || d >= 0) begin
            errors++;
            $display("FAIL timeout ws=%0d got=%0d exp=done", k, cyc);
        end
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic test_reset;
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (hro_w[k] !== 1'b1 || hresp_w[k] !== 2'b00 ||
                hrdata_w[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_state ws=%0d got=%b/%b/%h exp=1/00/0",
                         k, hro_w[k], hresp_w[k], hrdata_w[k]);
            end
        end
        @(negedge hclk);
        hreset = 1'b0;
        @(posedge hclk);
        #1;
    endtask

    task automatic test_fill;
        int cyc;
        logic [31:0] rd;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 64; i++) begin
                set_t(i, 1'b1, (i == 0) ? 2'b10 : 2'b11, 32'(i * 4), 1'b1,
                      $urandom);
            end
            run(k, 64, cyc, rd);
            checks++;
            if (cyc != 1 + 64 * (k + 1)) begin
                errors++;
                $display("FAIL fill_cycles ws=%0d got=%0d exp=%0d",
                         k, cyc, 1 + 64 * (k + 1));
            end
        end
    endtask

    task automatic test_write_read;
        int cyc;
        logic [31:0] rd;
        set_t(0, 1'b1, 2'b10, 32'h10, 1'b1, 32'hDEADBEEF);
        set_t(1, 1'b1, 2'b10, 32'h10, 1'b0, 32'h0);
        run(1, 2, cyc, rd);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read got=%h exp=deadbeef", rd);
        end
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL write_read_cycles got=%0d exp=5", cyc);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [31:0] rd;
        set_t(0, 1'b1, 2'b10, 32'h04, 1'b1, 32'h12345678);
        set_t(1, 1'b1, 2'b11, 32'h04, 1'b0, 32'h0);
        run(0, 2, cyc, rd);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL back_to_back got=%h exp=12345678", rd);
        end
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL back_to_back_cycles got=%0d exp=3", cyc);
        end
    endtask

    task automatic test_errors;
        int cyc;
        logic [31:0] rd;
        logic [31:0] old0;
        old0 = ref_mem[1][0];
        set_t(0, 1'b1, 2'b10, 32'h102, 1'b1, 32'h11111111);
        set_t(1, 1'b1, 2'b10, 32'h100, 1'b1, 32'h22222222);
        set_t(2, 1'b1, 2'b10, 32'h000, 1'b0, 32'h0);
        set_t(3, 1'b1, 2'b00, 32'h000, 1'b0, 32'h0);
        run(1, 4, cyc, rd);
        checks++;
        if (rd !== old0) begin
            errors++;
            $display("FAIL error_no_write got=%h exp=%h", rd, old0);
        end
        checks++;
        if (cyc != 7) begin
            errors++;
            $display("FAIL error_cycles got=%0d exp=7", cyc);
        end
    endtask

    task automatic test_no_xfer;
        int cyc;
        logic [31:0] rd;
        logic [31:0] old2;
        old2 = ref_mem[1][2];
        set_t(0, 1'b1, 2'b01, 32'h08, 1'b1, 32'hAAAA0001);
        set_t(1, 1'b1, 2'b00, 32'h08, 1'b1, 32'hAAAA0002);
        set_t(2, 1'b0, 2'b10, 32'h08, 1'b1, 32'hAAAA0003);
        set_t(3, 1'b1, 2'b10, 32'h08, 1'b0, 32'h0);
        run(1, 4, cyc, rd);
        checks++;
        if (rd !== old2) begin
            errors++;
            $display("FAIL no_xfer_write got=%h exp=%h", rd, old2);
        end
    endtask

    task automatic test_burst;
        int cyc;
        logic [31:0] rd;
        logic [31:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = $urandom;
            set_t(i, 1'b1, (i == 0) ? 2'b10 : 2'b11, 32'h20 + 32'(4 * i),
                  1'b1, v[i]);
            set_t(i + 4, 1'b1, (i == 0) ? 2'b10 : 2'b11,
                  32'h20 + 32'(4 * i), 1'b0, 32'h0);
        end
        run(2, 8, cyc, rd);
        checks++;
        if (cyc != 25) begin
            errors++;
            $display("FAIL burst_cycles got=%0d exp=25", cyc);
        end
        checks++;
        if (rd !== v[3]) begin
            errors++;
            $display("FAIL burst_last got=%h exp=%h", rd, v[3]);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic [31:0] rd;
        logic [31:0] old4;
        old4 = ref_mem[1][4];
        act    = 1;
        hsel   = 1'b1;
        haddr  = 32'h10;
        hwrite = 1'b1;
        htrans = 2'b10;
        @(posedge hclk);
        #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = ~old4;
        @(negedge hclk);
        checks++;
        if (hro_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait got=%b exp=0", hro_w[1]);
        end
        hreset = 1'b1;
        #1;
        checks++;
        if (hro_w[1] !== 1'b1 || hresp_w[1] !== 2'b00 ||
            hrdata_w[1] !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got=%b/%b/%h exp=1/00/0",
                     hro_w[1], hresp_w[1], hrdata_w[1]);
        end
        @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b0;
        @(posedge hclk);
        #1;
        set_t(0, 1'b1, 2'b10, 32'h10, 1'b0, 32'h0);
        run(1, 1, cyc, rd);
        checks++;
        if (rd !== old4) begin
            errors++;
            $display("FAIL reset_mid_mem got=%h exp=%h", rd, old4);
        end
    endtask

    task automatic test_random;
        int cyc;
        logic [31:0] rd;
        logic [31:0] a;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 48; i++) begin
                case ($urandom_range(0, 7))
                    0: a = {$urandom} | 32'h0000_0100;
                    1: a = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
                    default: a = {24'd0, 6'($urandom), 2'b00};
                endcase
                set_t(i, ($urandom_range(0, 9) != 0),
                      ($urandom_range(0, 5) == 0) ? 2'($urandom) :
                      2'($urandom_range(2, 3)),
                      a, 1'($urandom), $urandom);
            end
            run(k, 48, cyc, rd);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_write_read;
        test_back_to_back;
        test_errors;
        test_no_xfer;
        test_burst;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
